cmd_parser: RTL and testbench

CMD_PARSER -- requirements
Module: cmd_parser

---
 rtl/cmd_parser.sv | 206 ++++++++++++++++++++
 tb/tb_cmd_parser.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_parser.sv
// cmd_parser
// Byte-stream command interpreter for a character-cell text display.
// Printable bytes become character writes at the cursor. CR, LF, BS, TAB
// and BEL act as terminal controls. ESC introduces cursor moves: A/B/C/D
// step the cursor, H homes it, and Y <row+0x20> <col+0x20> places it
// directly.
//
// Ports
//   clk            system clock
//   clr            asynchronous active-high reset
//   px_clk         half-rate pixel clock level; bytes are taken only while low
//   data, valid    incoming byte and its qualifier
//   ready          combinational accept, equal to ~px_clk
//   new_char       character to store at the current cursor cell
//   new_char_wen   one-clk write strobe for new_char
//   new_cursor_x   cursor column
//   new_cursor_y   cursor row
//   new_cursor_wen one-clk strobe, cursor position changed or was set
//   scroll         one-clk strobe, scroll screen up one line
//   bell           one-clk strobe, BEL received
module cmd_parser #(
  parameter int COLS     = 80,
  parameter int ROWS     = 24,
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                px_clk,
  input  logic [7:0]          data,
  input  logic                valid,
  output logic                ready,
  output logic [7:0]          new_char,
  output logic                new_char_wen,
  output logic [COL_BITS-1:0] new_cursor_x,
  output logic [ROW_BITS-1:0] new_cursor_y,
  output logic                new_cursor_wen,
  output logic                scroll,
  output logic                bell
);

  typedef enum logic [1:0] {NORMAL, ESC, ESC_ROW, ESC_COL} state_t;

  localparam logic [COL_BITS-1:0] X_MAX = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] Y_MAX = ROW_BITS'(ROWS - 1);

  state_t              state_q, state_d;
  logic [7:0]          char_q, char_d;
  logic [COL_BITS-1:0] x_q, x_d;
  logic [ROW_BITS-1:0] y_q, y_d;
  logic [7:0]          row_q, row_d;
  logic                char_wen_q, char_wen_d;
  logic                cur_wen_q, cur_wen_d;
  logic                scroll_q, scroll_d;
  logic                bell_q, bell_d;

  logic                accept;
  logic [7:0]          coord;
  logic [COL_BITS:0]   tab_sum;
  logic [COL_BITS-1:0] tab_x;

  // px_clk high blocks acceptance, so bytes arrive at most every other clk.
  assign ready  = ~px_clk;
  assign accept = ready & valid;

  // Y coordinates arrive offset by 0x20; bytes below 0x20 wrap to >= 0xE0,
  // which is always out of range.
  assign coord = data - 8'h20;

  // Next tab stop is the next multiple of 8, clamped to the last column.
  // One extra bit keeps (x|7)+1 from wrapping when COLS is a power of two.
  assign tab_sum = {1'b0, x_q | COL_BITS'(7)} + (COL_BITS + 1)'(1);
  assign tab_x   = (tab_sum > {1'b0, X_MAX}) ? X_MAX : tab_sum[COL_BITS-1:0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= NORMAL;
      char_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_q      <= '0;
      char_wen_q <= 1'b0;
      cur_wen_q  <= 1'b0;
      scroll_q   <= 1'b0;
      bell_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      char_q     <= char_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_q      <= row_d;
      char_wen_q <= char_wen_d;
      cur_wen_q  <= cur_wen_d;
      scroll_q   <= scroll_d;
      bell_q     <= bell_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    char_d     = char_q;
    x_d        = x_q;
    y_d        = y_q;
    row_d      = row_q;
    char_wen_d = 1'b0;
    cur_wen_d  = 1'b0;
    scroll_d   = 1'b0;
    bell_d     = 1'b0;

    if (accept) begin
      unique case (state_q)
        NORMAL: begin
          if (data >= 8'h20 && data <= 8'h7E) begin
            // The cursor parks on the last column rather than wrapping.
            char_d     = data;
            char_wen_d = 1'b1;
            if (x_q < X_MAX) begin
              x_d       = x_q + COL_BITS'(1);
              cur_wen_d = 1'b1;
            end
          end else begin
            case (data)
              8'h0D: begin
                x_d       = '0;
                cur_wen_d = (x_q != '0);
              end
              8'h0A: begin
                if (y_q < Y_MAX) begin
                  y_d       = y_q + ROW_BITS'(1);
                  cur_wen_d = 1'b1;
                end else begin
                  scroll_d = 1'b1;
                end
              end
              8'h08: begin
                if (x_q != '0) begin
                  x_d       = x_q - COL_BITS'(1);
                  cur_wen_d = 1'b1;
                end
              end
              8'h09: begin
                x_d       = tab_x;
                cur_wen_d = (tab_x != x_q);
              end
              8'h07: bell_d = 1'b1;
              8'h1B: state_d = ESC;
              default: ;
            endcase
          end
        end

        ESC: begin
          state_d = NORMAL;
          case (data)
            8'h41: if (y_q != '0) begin
              y_d       = y_q - ROW_BITS'(1);
              cur_wen_d = 1'b1;
            end
            8'h42: if (y_q < Y_MAX) begin
              y_d       = y_q + ROW_BITS'(1);
              cur_wen_d = 1'b1;
            end
            8'h43: if (x_q < X_MAX) begin
              x_d       = x_q + COL_BITS'(1);
              cur_wen_d = 1'b1;
            end
            8'h44: if (x_q != '0) begin
              x_d       = x_q - COL_BITS'(1);
              cur_wen_d = 1'b1;
            end
            8'h48: begin
              x_d       = '0;
              y_d       = '0;
              cur_wen_d = 1'b1;
            end
            8'h59: state_d = ESC_ROW;
            8'h1B: state_d = ESC;
            default: ;
          endcase
        end

        ESC_ROW: begin
          row_d   = coord;
          state_d = ESC_COL;
        end

        ESC_COL: begin
          // Out-of-range coordinates leave that axis alone but still strobe.
          if (32'(row_q) < ROWS) y_d = ROW_BITS'(row_q);
          if (32'(coord) < COLS) x_d = COL_BITS'(coord);
          cur_wen_d = 1'b1;
          state_d   = NORMAL;
        end
      endcase
    end
  end

  assign new_char       = char_q;
  assign new_char_wen   = char_wen_q;
  assign new_cursor_x   = x_q;
  assign new_cursor_y   = y_q;
  assign new_cursor_wen = cur_wen_q;
  assign scroll         = scroll_q;
  assign bell           = bell_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Testbench for cmd_parser: a table of bytes with hand-computed expected
// outputs, followed by hand-written sequences for reset mid-sequence and
// px_clk-gated acceptance.
module tb_cmd_parser;

  logic       clk;
  logic       clr;
  logic       px_clk;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [7:0] new_char;
  logic       new_char_wen;
  logic [6:0] new_cursor_x;
  logic [4:0] new_cursor_y;
  logic       new_cursor_wen;
  logic       scroll;
  logic       bell;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [7:0] d;
    logic [7:0] ch;
    logic       cwen;
    logic [6:0] x;
    logic [4:0] y;
    logic       xwen;
    logic       scr;
    logic       bel;
  } vec_t;

  vec_t vecs[$];

  cmd_parser dut (
    .clk            (clk),
    .clr            (clr),
    .px_clk         (px_clk),
    .data           (data),
    .valid          (valid),
    .ready          (ready),
    .new_char       (new_char),
    .new_char_wen   (new_char_wen),
    .new_cursor_x   (new_cursor_x),
    .new_cursor_y   (new_cursor_y),
    .new_cursor_wen (new_cursor_wen),
    .scroll         (scroll),
    .bell           (bell)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] actualOut();
    return {new_char, new_char_wen, new_cursor_x, new_cursor_y,
            new_cursor_wen, scroll, bell};
  endfunction

  function automatic void addVec(input logic [7:0] d, input logic [7:0] ch,
                                 input logic cwen, input logic [6:0] x,
                                 input logic [4:0] y, input logic xwen,
                                 input logic scr, input logic bel);
    vec_t v;
    v.d = d; v.ch = ch; v.cwen = cwen; v.x = x; v.y = y;
    v.xwen = xwen; v.scr = scr; v.bel = bel;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [23:0] act,
                             input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got ch=%h cw=%b x=%0d y=%0d xw=%b scr=%b bel=%b, want ch=%h cw=%b x=%0d y=%0d xw=%b scr=%b bel=%b",
               name, act[23:16], act[15], act[14:8], act[7:3], act[2], act[1], act[0],
               exp[23:16], exp[15], exp[14:8], exp[7:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Present one byte for a single accepting clk, then sample just after it.
  task automatic applyStimulus(input logic [7:0] d);
    @(negedge clk);
    px_clk = 1'b0;
    valid  = 1'b1;
    data   = d;
    @(posedge clk);
    #1;
  endtask

  // A clk with valid held but px_clk high: nothing may be accepted.
  task automatic idleCycle();
    @(negedge clk);
    px_clk = 1'b1;
    valid  = 1'b1;
    data   = 8'h41;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] exp;
    int          wen_count;

    n_cmp  = 0;
    n_err  = 0;
    px_clk = 1'b1;
    valid  = 1'b0;
    data   = 8'h00;
    clr    = 1'b1;

    //      data   ch     cw x   y   xw s  b
    addVec(8'h41, 8'h41, 1, 1,  0,  1, 0, 0);
    addVec(8'h1B, 8'h41, 0, 1,  0,  0, 0, 0);
    addVec(8'h59, 8'h41, 0, 1,  0,  0, 0, 0);
    addVec(8'h25, 8'h41, 0, 1,  0,  0, 0, 0);
    addVec(8'h2A, 8'h41, 0, 10, 5,  1, 0, 0);
    addVec(8'h09, 8'h41, 0, 16, 5,  1, 0, 0);
    addVec(8'h08, 8'h41, 0, 15, 5,  1, 0, 0);
    addVec(8'h0D, 8'h41, 0, 0,  5,  1, 0, 0);
    addVec(8'h0D, 8'h41, 0, 0,  5,  0, 0, 0);
    addVec(8'h08, 8'h41, 0, 0,  5,  0, 0, 0);
    addVec(8'h03, 8'h41, 0, 0,  5,  0, 0, 0);
    addVec(8'h1B, 8'h41, 0, 0,  5,  0, 0, 0);
    addVec(8'h59, 8'h41, 0, 0,  5,  0, 0, 0);
    addVec(8'h37, 8'h41, 0, 0,  5,  0, 0, 0);
    addVec(8'h6F, 8'h41, 0, 79, 23, 1, 0, 0);
    addVec(8'h42, 8'h42, 1, 79, 23, 0, 0, 0);
    addVec(8'h0A, 8'h42, 0, 79, 23, 0, 1, 0);
    addVec(8'h1B, 8'h42, 0, 79, 23, 0, 0, 0);
    addVec(8'h43, 8'h42, 0, 79, 23, 0, 0, 0);
    addVec(8'h09, 8'h42, 0, 79, 23, 0, 0, 0);
    addVec(8'h1B, 8'h42, 0, 79, 23, 0, 0, 0);
    addVec(8'h48, 8'h42, 0, 0,  0,  1, 0, 0);
    addVec(8'h1B, 8'h42, 0, 0,  0,  0, 0, 0);
    addVec(8'h41, 8'h42, 0, 0,  0,  0, 0, 0);
    addVec(8'h1B, 8'h42, 0, 0,  0,  0, 0, 0);
    addVec(8'h44, 8'h42, 0, 0,  0,  0, 0, 0);
    addVec(8'h1B, 8'h42, 0, 0,  0,  0, 0, 0);
    addVec(8'h42, 8'h42, 0, 0,  1,  1, 0, 0);
    addVec(8'h1B, 8'h42, 0, 0,  1,  0, 0, 0);
    addVec(8'h43, 8'h42, 0, 1,  1,  1, 0, 0);
    addVec(8'h1B, 8'h42, 0, 1,  1,  0, 0, 0);
    addVec(8'h43, 8'h42, 0, 2,  1,  1, 0, 0);
    addVec(8'h1B, 8'h42, 0, 2,  1,  0, 0, 0);
    addVec(8'h43, 8'h42, 0, 3,  1,  1, 0, 0);
    addVec(8'h09, 8'h42, 0, 8,  1,  1, 0, 0);
    addVec(8'h1B, 8'h42, 0, 8,  1,  0, 0, 0);
    addVec(8'h59, 8'h42, 0, 8,  1,  0, 0, 0);
    addVec(8'h38, 8'h42, 0, 8,  1,  0, 0, 0);
    addVec(8'h2A, 8'h42, 0, 10, 1,  1, 0, 0);
    addVec(8'h1B, 8'h42, 0, 10, 1,  0, 0, 0);
    addVec(8'h59, 8'h42, 0, 10, 1,  0, 0, 0);
    addVec(8'h05, 8'h42, 0, 10, 1,  0, 0, 0);
    addVec(8'h70, 8'h42, 0, 10, 1,  1, 0, 0);
    addVec(8'h1B, 8'h42, 0, 10, 1,  0, 0, 0);
    addVec(8'h1B, 8'h42, 0, 10, 1,  0, 0, 0);
    addVec(8'h42, 8'h42, 0, 10, 2,  1, 0, 0);
    addVec(8'h1B, 8'h42, 0, 10, 2,  0, 0, 0);
    addVec(8'h5A, 8'h42, 0, 10, 2,  0, 0, 0);
    addVec(8'h61, 8'h61, 1, 11, 2,  1, 0, 0);
    addVec(8'h07, 8'h61, 0, 11, 2,  0, 0, 1);
    addVec(8'h0A, 8'h61, 0, 11, 3,  1, 0, 0);
    addVec(8'h7F, 8'h61, 0, 11, 3,  0, 0, 0);
    addVec(8'hFF, 8'h61, 0, 11, 3,  0, 0, 0);
    addVec(8'h1B, 8'h61, 0, 11, 3,  0, 0, 0);
    addVec(8'h59, 8'h61, 0, 11, 3,  0, 0, 0);
    addVec(8'h20, 8'h61, 0, 11, 3,  0, 0, 0);
    addVec(8'h6E, 8'h61, 0, 78, 0,  1, 0, 0);
    addVec(8'h09, 8'h61, 0, 79, 0,  1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", actualOut(), 24'h0);
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].d);
      exp = {vecs[i].ch, vecs[i].cwen, vecs[i].x, vecs[i].y,
             vecs[i].xwen, vecs[i].scr, vecs[i].bel};
      checkOutput($sformatf("vec%0d_%h", i, vecs[i].d), actualOut(), exp);
      idleCycle();
      exp = {vecs[i].ch, 1'b0, vecs[i].x, vecs[i].y, 3'b000};
      checkOutput($sformatf("vec%0d_idle", i), actualOut(), exp);
    end

    // Reset in the middle of an ESC Y sequence, then a plain character.
    applyStimulus(8'h1B);
    applyStimulus(8'h59);
    applyStimulus(8'h25);
    @(negedge clk);
    valid = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    checkOutput("clr_async", actualOut(), 24'h0);
    @(negedge clk);
    clr = 1'b0;
    applyStimulus(8'h5A);
    checkOutput("after_clr_Z", actualOut(), {8'h5A, 1'b1, 7'd1, 5'd0, 3'b100});

    // valid held while px_clk toggles every clk: only the low-phase clks count.
    wen_count = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      px_clk = i[0];
      valid  = 1'b1;
      data   = 8'h62;
      #1;
      n_cmp++;
      if (ready !== ~px_clk) begin
        n_err++;
        $display("[TB] FAIL ready_%0d: got %b, want %b", i, ready, ~px_clk);
      end
      @(posedge clk);
      #1;
      if (new_char_wen) wen_count++;
    end
    valid = 1'b0;
    n_cmp++;
    if (wen_count != 4) begin
      n_err++;
      $display("[TB] FAIL toggle_accepts: got %0d, want 4", wen_count);
    end
    @(posedge clk);
    #1;
    checkOutput("toggle_final", actualOut(), {8'h62, 1'b0, 7'd5, 5'd0, 3'b000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
